// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word-fall-through read data,
// fill level, almost-full/almost-empty thresholds and sticky error flags.
module sync_fifo #(
  parameter int unsigned DATASIZE   = 12,
  parameter int unsigned ADDRSIZE   = 3,
  parameter int unsigned AFULL_LVL  = 6,
  parameter int unsigned AEMPTY_LVL = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                winc,
  input  logic [DATASIZE-1:0] wdata,
  output logic                wfull,
  output logic                wafull,
  input  logic                rinc,
  output logic [DATASIZE-1:0] rdata,
  output logic                rempty,
  output logic                raempty,
  output logic [ADDRSIZE:0]   count,
  output logic                overflow,
  output logic                underflow,
  input  logic                clr_err
);

  localparam int unsigned DEPTH = 1 << ADDRSIZE;
  localparam int unsigned PW    = ADDRSIZE + 1;

  logic [DATASIZE-1:0] mem [DEPTH];

  logic [PW-1:0] wptr, rptr;
  logic [PW-1:0] wptr_next, rptr_next;
  logic [PW-1:0] count_next;
  logic          wr_acc, rd_acc;
  logic          overflow_next, underflow_next;

  // Requests are qualified by this cycle's registered flags.
  assign wr_acc = winc & ~wfull;
  assign rd_acc = rinc & ~rempty;

  // Next pointers; the extra MSB keeps full and empty distinguishable,
  // so the level is simply the modular pointer distance.
  always_comb begin
    wptr_next  = wptr;
    rptr_next  = rptr;
    if (wr_acc) wptr_next = wptr + PW'(1);
    if (rd_acc) rptr_next = rptr + PW'(1);
    count_next = wptr_next - rptr_next;
  end

  // Sticky error flags: a fresh event in the same cycle beats clr_err.
  always_comb begin
    overflow_next  = overflow;
    underflow_next = underflow;
    if (clr_err) begin
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end
    if (winc & wfull)  overflow_next  = 1'b1;
    if (rinc & rempty) underflow_next = 1'b1;
  end

  // Pointer, level and flag registers, all derived from the next level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      wfull   <= 1'b0;
      rempty  <= 1'b1;
      wafull  <= 1'b0;
      raempty <= 1'b1;
    end else begin
      wptr    <= wptr_next;
      rptr    <= rptr_next;
      count   <= count_next;
      wfull   <= (count_next == PW'(DEPTH));
      rempty  <= (count_next == '0);
      wafull  <= (count_next >= PW'(AFULL_LVL));
      raempty <= (count_next <= PW'(AEMPTY_LVL));
    end
  end

  // Error flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= overflow_next;
      underflow <= underflow_next;
    end
  end

  // Storage array; contents are never reset, rempty hides stale words.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr[ADDRSIZE-1:0]] <= wdata;
  end

  // Head of queue is presented without a read cycle.
  assign rdata = mem[rptr[ADDRSIZE-1:0]];

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed and randomized checks of sync_fifo against a queue model.
module tb_sync_fifo;

  localparam int unsigned DATASIZE   = 12;
  localparam int unsigned ADDRSIZE   = 3;
  localparam int unsigned DEPTH      = 1 << ADDRSIZE;
  localparam int unsigned AFULL_LVL  = 6;
  localparam int unsigned AEMPTY_LVL = 1;

  logic                clk;
  logic                rst_n;
  logic                winc;
  logic [DATASIZE-1:0] wdata;
  logic                wfull;
  logic                wafull;
  logic                rinc;
  logic [DATASIZE-1:0] rdata;
  logic                rempty;
  logic                raempty;
  logic [ADDRSIZE:0]   count;
  logic                overflow;
  logic                underflow;
  logic                clr_err;

  sync_fifo #(
    .DATASIZE  (DATASIZE),
    .ADDRSIZE  (ADDRSIZE),
    .AFULL_LVL (AFULL_LVL),
    .AEMPTY_LVL(AEMPTY_LVL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .winc     (winc),
    .wdata    (wdata),
    .wfull    (wfull),
    .wafull   (wafull),
    .rinc     (rinc),
    .rdata    (rdata),
    .rempty   (rempty),
    .raempty  (raempty),
    .count    (count),
    .overflow (overflow),
    .underflow(underflow),
    .clr_err  (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain queue of words plus two sticky bits.
  int unsigned q[$];
  bit          m_ovf;
  bit          m_unf;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int unsigned lvl;
    lvl = q.size();
    chk({tag, ".count"},     32'(count),     lvl);
    chk({tag, ".wfull"},     32'(wfull),     32'(lvl == DEPTH));
    chk({tag, ".rempty"},    32'(rempty),    32'(lvl == 0));
    chk({tag, ".wafull"},    32'(wafull),    32'(lvl >= AFULL_LVL));
    chk({tag, ".raempty"},   32'(raempty),   32'(lvl <= AEMPTY_LVL));
    chk({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
    if (lvl != 0) chk({tag, ".rdata"}, 32'(rdata), q[0]);
  endtask

  // One clock cycle of stimulus; called and returns at a falling edge.
  task automatic step(input string tag, input bit w, input int unsigned d,
                      input bit r, input bit c);
    bit full, empty;
    full    = (q.size() == DEPTH);
    empty   = (q.size() == 0);
    winc    = w;
    wdata   = DATASIZE'(d);
    rinc    = r;
    clr_err = c;
    @(posedge clk);
    if (r && !empty) void'(q.pop_front());
    if (w && !full)  q.push_back(d & ((1 << DATASIZE) - 1));
    if (c) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (w && full)  m_ovf = 1'b1;
    if (r && empty) m_unf = 1'b1;
    @(negedge clk);
    winc    = 1'b0;
    rinc    = 1'b0;
    clr_err = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_all("reset");
  endtask

  initial begin
    int unsigned wbias;
    rst_n   = 1'b0;
    winc    = 1'b0;
    rinc    = 1'b0;
    clr_err = 1'b0;
    wdata   = '0;
    @(negedge clk);
    do_reset();

    // Fill with 1..8, then one rejected write.
    for (int i = 1; i <= 8; i++) step("fill", 1'b1, i, 1'b0, 1'b0);
    step("overfill", 1'b1, 32'h0ff, 1'b0, 1'b0);

    // Drain all eight words, then one rejected read.
    for (int i = 1; i <= 8; i++) step("drain", 1'b0, 0, 1'b1, 1'b0);
    step("overdrain", 1'b0, 0, 1'b1, 1'b0);

    // Clear with no concurrent event.
    step("clr_idle", 1'b0, 0, 1'b0, 1'b1);

    // Simultaneous write+read while empty.
    step("wr_rd_empty", 1'b1, 32'h0a1, 1'b1, 1'b0);
    step("clr_after_empty", 1'b0, 0, 1'b0, 1'b1);

    // Fill up, then simultaneous write+read while full.
    for (int i = 0; i < 7; i++) step("refill", 1'b1, 32'h0b0 + i, 1'b0, 1'b0);
    step("wr_rd_full", 1'b1, 32'h0ee, 1'b1, 1'b0);

    // Clear together with a write at full: overflow must persist.
    step("top_up", 1'b1, 32'h0c0, 1'b0, 1'b0);
    step("clr_vs_ovf", 1'b1, 32'h0dd, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step("drain2", 1'b0, 0, 1'b1, 1'b0);
    step("clr2", 1'b0, 0, 1'b0, 1'b1);

    // Steady-state streaming across pointer wrap.
    for (int i = 0; i < 3; i++) step("preload", 1'b1, 32'h100 + i, 1'b0, 1'b0);
    for (int i = 3; i < 23; i++) step("wrap", 1'b1, 32'h100 + i, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("unload", 1'b0, 0, 1'b1, 1'b0);

    // Randomized traffic with phases biased toward full and toward empty.
    for (int ph = 0; ph < 4; ph++) begin
      wbias = (ph % 2 == 0) ? 75 : 25;
      for (int i = 0; i < 100; i++)
        step("rand", $urandom_range(0, 99) < wbias, $urandom, $urandom_range(0, 99) < (100 - wbias),
             $urandom_range(0, 15) == 0);
    end

    // Asynchronous reset mid-operation with five words stored.
    do_reset();
    for (int i = 0; i < 5; i++) step("pre_arst", 1'b1, 32'h200 + i, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.count",   32'(count),   32'd0);
    chk("arst.rempty",  32'(rempty),  32'd1);
    chk("arst.raempty", 32'(raempty), 32'd1);
    chk("arst.wafull",  32'(wafull),  32'd0);
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all("post_arst");
    step("post_arst_wr", 1'b1, 32'h333, 1'b0, 1'b0);
    step("post_arst_rd", 1'b0, 0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock, parametrised FIFO that combines the dual-port memory array with its own pointer, level and flag logic. It is the successor to our bare FIFO memory block, for use where both sides of the buffer share one clock. It adds first-word-fall-through read data, a fill-level output, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. Typical use is rate smoothing between pipeline stages and command queues inside one clock domain.

Parameters:
DATASIZE, 12, data word width in bits
ADDRSIZE, 3, address bits; DEPTH = 1<<ADDRSIZE words
AFULL_LVL, 6, wafull asserts when count >= AFULL_LVL; legal range 1..DEPTH
AEMPTY_LVL, 1, raempty asserts when count <= AEMPTY_LVL; legal range 0..DEPTH-1

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
winc  input  1  write request
wdata  input  DATASIZE  write data
wfull  output  1  FIFO full (registered)
wafull  output  1  almost full (registered)
rinc  input  1  read/pop request
rdata  output  DATASIZE  head-of-queue word, valid whenever rempty=0
rempty  output  1  FIFO empty (registered)
raempty  output  1  almost empty (registered)
count  output  ADDRSIZE+1  current fill level, 0..DEPTH
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty
clr_err  input  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (rst_n=0, asynchronous): wptr=rptr=0, count=0, rempty=1, raempty=1, wfull=0, wafull=0 (AFULL_LVL>=1), overflow=0, underflow=0. Memory array is not reset.
- Pointers: wptr and rptr are ADDRSIZE+1-bit binary; the low ADDRSIZE bits address memory; the MSB handles wrap. Both wrap naturally from 2*DEPTH-1 to 0.
- wr_acc = winc & ~wfull; rd_acc = rinc & ~rempty. Accepted actions only are evaluated against registered flags of the current cycle.
- Write: on wr_acc, mem[wptr[ADDRSIZE-1:0]] <= wdata and wptr increments.
- Read: rdata = mem[rptr[ADDRSIZE-1:0]] combinationally (first-word fall-through). On rd_acc, rptr increments. rdata is don't-care while rempty=1.
- First-word latency: a word written at edge N is visible on rdata, with rempty=0, after edge N.
- Level: count_next = count + wr_acc - rd_acc. Flags are registered from count_next:
  - wfull = (count_next == DEPTH)
  - rempty = (count_next == 0)
  - wafull = (count_next >= AFULL_LVL)
  - raempty = (count_next <= AEMPTY_LVL)
- Simultaneous winc & rinc:
  - Neither full nor empty: both accepted; count unchanged; flags unchanged.
  - Empty: write accepted, read ignored (underflow set); next cycle count=1.
  - Full: read accepted, write ignored (overflow set); next cycle count=DEPTH-1.
- Errors: overflow <= 1 on winc & wfull; underflow <= 1 on rinc & rempty. Rejected operations do not alter pointers or memory. clr_err clears both flags, but a new error event in the same cycle wins (flag stays 1).
- Mid-operation reset: all state returns to reset values immediately. Data in flight is discarded; post-reset memory contents are not observable because rempty=1.

Test Plan:
- Reset: rst_n low then high -> count=0, rempty=1, raempty=1, wfull=0, wafull=0, overflow=underflow=0.
- Fill: 8 writes of 0x001..0x008 (defaults) -> wafull=1 after write 6, wfull=1 after write 8, count=8. A 9th winc -> overflow=1, count stays 8, data unchanged.
- Drain: 8 reads -> rdata sequence 0x001..0x008 with rdata=0x001 visible before the first rinc. raempty=1 when count<=1, rempty=1 after the 8th read. An extra rinc -> underflow=1, count=0.
- Wrap-around: 20 cycles of one write plus one read per cycle after pre-loading 3 words -> count constant at 3, data strictly in order across pointer wrap, no flag change.
- Boundary simultaneity: winc&rinc while empty -> count=1, underflow=1. winc&rinc while full -> count=7, overflow=1, the written word is absent from the output sequence.
- Error clear / reset mid-operation: clr_err with no event -> flags 0; clr_err together with winc at full -> overflow remains 1. Assert rst_n=0 with count=5 -> count=0, rempty=1 asynchronously, before the next clk edge.
